// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, constants and typedefs for the register file slice
package cpu_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    // Architectural zero register index
    localparam int REG_ZERO = 0;

    typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
    typedef logic [DEF_DATA_W-1:0] word_t;

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register pending scoreboard with stall and popcount
//
// Ports:
//   clk, rst           clock and asynchronous active-high reset
//   issue_en_i/addr_i  producer issued; marks its destination pending
//   clr_en_i/addr_i    write-back; clears the destination's pending bit
//   rs_addr_i/rt_addr_i operand addresses checked for hazards
//   stall_o            either operand is still pending
//   pending_cnt_o      number of pending registers
module reg_scoreboard
    import cpu_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_en_i,
    input  logic [ADDR_W-1:0] issue_addr_i,
    input  logic              clr_en_i,
    input  logic [ADDR_W-1:0] clr_addr_i,
    input  logic [ADDR_W-1:0] rs_addr_i,
    input  logic [ADDR_W-1:0] rt_addr_i,
    output logic              stall_o,
    output logic [ADDR_W:0]   pending_cnt_o
);

    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;

    // Clear first, then set: when both hit the same register the newer
    // producer keeps it pending.
    always_comb begin
        pending_d = pending_q;
        if (clr_en_i && (clr_addr_i != ZERO_ADDR)) begin
            pending_d[clr_addr_i] = 1'b0;
        end
        if (issue_en_i && (issue_addr_i != ZERO_ADDR)) begin
            pending_d[issue_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign stall_o = pending_q[rs_addr_i] | pending_q[rt_addr_i];

    // Recounted from the vector every cycle so it can never drift.
    always_comb begin
        pending_cnt_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            pending_cnt_o = pending_cnt_o + (ADDR_W+1)'(pending_q[i]);
        end
    end

endmodule

// File: rtl/reg_file_wb.sv
// rtl/reg_file_wb.sv - register file with one-entry write-back buffer, read bypass and scoreboard
//
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   rs_addr/rs_data          read port A (combinational)
//   rt_addr/rt_data          read port B (combinational)
//   wr_en/wr_addr/wr_data    write-back request
//   issue_en/issue_addr      issued instruction's destination
//   stall                    operand hazard on rs or rt
//   pending_cnt              number of pending registers
module reg_file_wb
    import cpu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              stall,
    output logic [ADDR_W:0]   pending_cnt
);

    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] mem_q [NUM_REGS];

    logic              wb_valid_q, wb_valid_d;
    logic [ADDR_W-1:0] wb_addr_q,  wb_addr_d;
    logic [DATA_W-1:0] wb_data_q,  wb_data_d;

    // Writes to r0 never enter the buffer, so the array entry 0 stays zero.
    always_comb begin
        wb_valid_d = 1'b0;
        wb_addr_d  = '0;
        wb_data_d  = '0;
        if (wr_en && (wr_addr != ZERO_ADDR)) begin
            wb_valid_d = 1'b1;
            wb_addr_d  = wr_addr;
            wb_data_d  = wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
        end
    end

    // Buffer drains into the array on the edge after capture, in parallel
    // with the buffer taking the next write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wb_valid_q) begin
            mem_q[wb_addr_q] <= wb_data_q;
        end
    end

    // Read mux: r0, then the pending buffer entry, then the array.
    always_comb begin
        rs_data = mem_q[rs_addr];
        if (rs_addr == ZERO_ADDR) begin
            rs_data = '0;
        end else if (wb_valid_q && (wb_addr_q == rs_addr)) begin
            rs_data = wb_data_q;
        end
    end

    always_comb begin
        rt_data = mem_q[rt_addr];
        if (rt_addr == ZERO_ADDR) begin
            rt_data = '0;
        end else if (wb_valid_q && (wb_addr_q == rt_addr)) begin
            rt_data = wb_data_q;
        end
    end

    reg_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk           (clk),
        .rst           (rst),
        .issue_en_i    (issue_en),
        .issue_addr_i  (issue_addr),
        .clr_en_i      (wr_en),
        .clr_addr_i    (wr_addr),
        .rs_addr_i     (rs_addr),
        .rt_addr_i     (rt_addr),
        .stall_o       (stall),
        .pending_cnt_o (pending_cnt)
    );

endmodule

// File: tb/tb_reg_file_wb.sv
// tb/tb_reg_file_wb.sv - randomized self-checking bench for reg_file_wb
module tb_reg_file_wb;

    logic        clk;
    logic        rst;
    logic [4:0]  rs_addr, rt_addr, wr_addr, issue_addr;
    logic [31:0] rs_data, rt_data, wr_data;
    logic        wr_en, issue_en, stall;
    logic [5:0]  pending_cnt;

    int n_checks;
    int n_pass;

    // Architectural view: a write is visible to readers from the next cycle.
    logic [31:0] ref_regs [32];
    bit          ref_pend [32];

    reg_file_wb dut (
        .clk         (clk),
        .rst         (rst),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .issue_en    (issue_en),
        .issue_addr  (issue_addr),
        .stall       (stall),
        .pending_cnt (pending_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_read(input logic [4:0] a);
        return (a == 5'd0) ? 32'h0 : ref_regs[a];
    endfunction

    function automatic int ref_count();
        int c = 0;
        for (int i = 0; i < 32; i++) c += ref_pend[i] ? 1 : 0;
        return c;
    endfunction

    task automatic ref_reset();
        for (int i = 0; i < 32; i++) begin
            ref_regs[i] = 32'h0;
            ref_pend[i] = 1'b0;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_rs"},  rs_data, ref_read(rs_addr));
        check({tag, "_rt"},  rt_data, ref_read(rt_addr));
        check({tag, "_stall"}, {31'd0, stall}, {31'd0, ref_pend[rs_addr] | ref_pend[rt_addr]});
        check({tag, "_cnt"}, {26'd0, pending_cnt}, ref_count());
    endtask

    // Drive one cycle, check outputs at the falling edge, advance the model
    // on the rising edge; returns 1 time unit after that edge.
    task automatic step(input string tag, input bit we, input logic [4:0] wa, input logic [31:0] wd,
                        input bit ie, input logic [4:0] ia, input logic [4:0] rs, input logic [4:0] rt);
        wr_en = we; wr_addr = wa; wr_data = wd;
        issue_en = ie; issue_addr = ia;
        rs_addr = rs; rt_addr = rt;
        @(negedge clk);
        check_model(tag);
        @(posedge clk);
        if (we && wa != 5'd0) begin
            ref_regs[wa] = wd;
            ref_pend[wa] = 1'b0;
        end
        if (ie && ia != 5'd0) ref_pend[ia] = 1'b1;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        ref_reset();
        rst = 1'b1;
        wr_en = 0; wr_addr = 0; wr_data = 0;
        issue_en = 0; issue_addr = 0; rs_addr = 5; rt_addr = 3;
        #2;
        check("reset_rs", rs_data, 32'h0);
        check("reset_cnt", {26'd0, pending_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Bypass: old value before the edge, buffer after, array later
        step("byp_n", 1, 5'd3, 32'h12345678, 0, 5'd0, 5'd3, 5'd0);
        check("byp_buf", rs_data, 32'h12345678);
        step("byp_n1", 0, 5'd0, 32'h0, 0, 5'd0, 5'd3, 5'd3);
        check("byp_arr", rt_data, 32'h12345678);

        // Back-to-back writes
        step("b2b_1", 1, 5'd1, 32'h11, 0, 5'd0, 5'd1, 5'd2);
        step("b2b_2", 1, 5'd2, 32'h22, 0, 5'd0, 5'd1, 5'd2);
        step("b2b_3", 1, 5'd1, 32'h33, 0, 5'd0, 5'd1, 5'd2);
        rt_addr = 5'd1;
        #1 check("b2b_rt1", rt_data, 32'h33);
        step("b2b_idle", 0, 5'd0, 32'h0, 0, 5'd0, 5'd1, 5'd2);
        step("b2b_fin", 0, 5'd0, 32'h0, 0, 5'd0, 5'd1, 5'd2);
        check("b2b_r2", rt_data, 32'h22);

        // Zero register
        step("zero_w", 1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 5'd0, 5'd0);
        check("zero_rd", rs_data, 32'h0);
        check("zero_stall", {31'd0, stall}, 32'd0);
        check("zero_cnt", {26'd0, pending_cnt}, 32'd0);

        // Scoreboard set and clear
        step("sb_iss", 0, 5'd0, 32'h0, 1, 5'd7, 5'd7, 5'd0);
        check("sb_stall", {31'd0, stall}, 32'd1);
        check("sb_cnt1", {26'd0, pending_cnt}, 32'd1);
        step("sb_wr", 1, 5'd7, 32'h77, 0, 5'd0, 5'd7, 5'd0);
        check("sb_clr", {31'd0, stall}, 32'd0);
        check("sb_cnt0", {26'd0, pending_cnt}, 32'd0);

        // Set/clear collision: set wins
        step("col_pre", 0, 5'd0, 32'h0, 1, 5'd4, 5'd0, 5'd4);
        step("col_hit", 1, 5'd4, 32'h44, 1, 5'd4, 5'd0, 5'd4);
        check("col_stall", {31'd0, stall}, 32'd1);
        check("col_data", rt_data, 32'h44);
        step("col_post", 0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd4);

        // Mid-cycle asynchronous reset
        step("rst_w", 1, 5'd5, 32'hDEADBEEF, 1, 5'd6, 5'd5, 5'd6);
        wr_en = 0; issue_en = 0;
        #2;
        check("rst_pre_rs", rs_data, 32'hDEADBEEF);
        check("rst_pre_stall", {31'd0, stall}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_rs", rs_data, 32'h0);
        check("rst_mid_stall", {31'd0, stall}, 32'd0);
        check("rst_mid_cnt", {26'd0, pending_cnt}, 32'd0);
        ref_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_post_rs", rs_data, 32'h0);

        // Random traffic against the model
        for (int i = 0; i < 500; i++) begin
            step("rnd",
                 ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- General-purpose register file for the processor datapath; sits directly downstream of the 5-bit destination-register select mux.
- Consumes the selected write address, with write data and enable from write-back.
- Provides two combinational read ports to decode, with a one-entry write-back buffer bypassed to the readers.
- A per-register pending scoreboard raises a stall when an operand's producer has not yet written back.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W (derived localparam, 32)

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous reset, active-high
rs_addr  input  ADDR_W  read port A address
rt_addr  input  ADDR_W  read port B address
rs_data  output  DATA_W  read port A data (combinational)
rt_data  output  DATA_W  read port B data (combinational)
wr_en  input  1  write-back request this cycle
wr_addr  input  ADDR_W  destination address, driven by the destination-select mux
wr_data  input  DATA_W  write-back data
issue_en  input  1  instruction issued that will write issue_addr later
issue_addr  input  ADDR_W  destination of issuing instruction
stall  output  1  operand hazard: rs or rt pending
pending_cnt  output  ADDR_W+1  number of registers currently pending (0..31)

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset (async assert, any time, including mid-operation):
  - All NUM_REGS entries become 0.
  - wb_valid=0, wb_addr=0, wb_data=0.
  - pending=0, pending_cnt=0.
  - Hence rs_data=rt_data=0 and stall=0 while rst is high and after release.
- Register 0 is hardwired zero:
  - Reads of addr 0 return 0 regardless of buffer or array.
  - wr_en with wr_addr=0 is dropped; wb_valid is cleared at that edge.
  - issue_addr=0 never sets pending.
- Write path, two stages:
  - Edge N with wr_en=1 and wr_addr!=0: capture wb_valid=1, wb_addr, wb_data.
  - Edge N+1: if wb_valid, commit array[wb_addr]=wb_data. At the same edge the buffer is reloaded from the current wr_* inputs, or cleared if wr_en=0.
  - Back-to-back writes give one write per cycle, with no loss and no stall.
- Read priority, per port, combinational:
  - (1) addr==0 -> 0.
  - (2) wb_valid && wb_addr==addr -> wb_data.
  - (3) array[addr].
  - Same-cycle wr_data is NOT forwarded. A value written at edge N is visible to readers from cycle N+1 via the buffer.
- Scoreboard, pending[NUM_REGS-1:0]:
  - Set: issue_en && issue_addr!=0 sets pending[issue_addr] at the edge.
  - Clear: wr_en && wr_addr!=0 clears pending[wr_addr] at the edge.
  - Same edge, same address, set and clear: set wins (a newer producer exists).
  - Clear of a non-pending register is harmless.
  - stall = pending[rs_addr] | pending[rt_addr], combinational from registered state.
  - pending_cnt = popcount(pending), recomputed combinationally from the register vector. It is never an incremental counter, so it cannot drift.
- Writes without a prior issue are legal and update the array normally.

Decomposition:
- Shared package (cpu_pkg): DATA_W and ADDR_W defaults, REG_ZERO = 0 constant, reg_addr_t/word_t typedefs.
- One natural sub-module: reg_scoreboard, which holds the pending vector, set/clear priority, stall and pending_cnt.
- The array, write-back buffer and read mux stay in reg_file_wb.

Test Plan:
- Reset: write r5=0xDEADBEEF, then assert rst mid-cycle -> immediately rs_data(rs=5)=0, stall=0, pending_cnt=0; stays 0 after release.
- Bypass: edge N write r3=0x12345678, then read rs=3 in cycle N+1 -> 0x12345678 from the buffer. Same value in cycle N+2 from the array. In cycle N, before the edge, old value 0.
- Back-to-back: writes r1=0x11, r2=0x22, r1=0x33 on consecutive edges -> after idle, r1=0x33, r2=0x22; rt=1 in the cycle after the third write reads 0x33.
- Zero register: wr_en, wr_addr=0, wr_data=0xFFFFFFFF, plus issue_addr=0 -> rs=0 reads 0, stall=0, pending_cnt unchanged.
- Scoreboard: issue r7 -> next cycle stall=1 with rs=7, pending_cnt=1. Write r7 -> next cycle stall=0, pending_cnt=0.
- Set/clear collision: r4 pending. At the same edge issue r4 and write r4=0x44 -> pending[4] stays 1 (stall with rt=4), and rt_data=0x44 next cycle.
